// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage load/store port.
// One request is taken at a time. It is decoded for RV32I size and sign,
// checked for legality, delayed by WAIT_STATES cycles, and then answered.
// Handshake rules:
//   - A request transfers on a rising edge where req_valid && req_ready.
//   - A response transfers on a rising edge where rsp_valid && rsp_ready.
//   - rsp_valid, rsp_rdata and rsp_err hold stable until the response transfers.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic ZERO_WAIT = (WAIT_STATES == 0);

  generate
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
      $error("dmem_responder: WAIT_STATES must be in 0..15");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q, wdata_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem [DEPTH_WORDS];

  // Request actually being served: live inputs on the accept edge, the latched copy afterwards.
  logic [31:0] a_addr, a_wdata;
  logic        a_we;
  logic [2:0]  a_f3;
  logic        a_err, accept, ent_resp, mem_wr;
  logic [AW-1:0] idx;
  logic [31:0] rd_word, rd_shift, load_ext, wd;
  logic [3:0]  be;

  // Returns 1 for an illegal size, a store of an unsigned size, misalignment, or an out-of-range word.
  function automatic logic access_err(input logic [31:0] a, input logic we, input logic [2:0] f3);
    logic e;
    e = 1'b0;
    case (f3)
      3'b000:  e = 1'b0;
      3'b001:  e = a[0];
      3'b010:  e = |a[1:0];
      3'b100:  e = we;
      3'b101:  e = we | a[0];
      default: e = 1'b1;
    endcase
    if ({2'b00, a[31:2]} >= 32'(DEPTH_WORDS)) e = 1'b1;
    return e;
  endfunction

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign dbg_state = state_q;

  // Select the effective request and decode its lanes and load data.
  always_comb begin
    a_addr   = (state_q == IDLE) ? req_addr   : addr_q;
    a_wdata  = (state_q == IDLE) ? req_wdata  : wdata_q;
    a_we     = (state_q == IDLE) ? req_we     : we_q;
    a_f3     = (state_q == IDLE) ? req_funct3 : funct3_q;
    a_err    = access_err(a_addr, a_we, a_f3);
    ent_resp = ((state_q == IDLE) && accept && (a_err || ZERO_WAIT)) ||
               ((state_q == WAIT) && (cnt_q == 4'd0));
    mem_wr   = ent_resp && !a_err && a_we;
    idx      = a_addr[AW+1:2];
    rd_word  = mem[idx];
    rd_shift = rd_word >> {a_addr[1:0], 3'b000};
    case (a_f3)
      3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_ext = {24'd0, rd_shift[7:0]};
      3'b101:  load_ext = {16'd0, rd_shift[15:0]};
      default: load_ext = rd_word;
    endcase
    case (a_f3[1:0])
      2'b00: begin
        be = 4'b0001 << a_addr[1:0];
        wd = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        be = a_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{a_wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = a_wdata;
      end
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (a_err || ZERO_WAIT) ? RESP : WAIT;
      WAIT:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, request latch, wait counter and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && accept) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        we_q     <= req_we;
        funct3_q <= req_funct3;
        cnt_q    <= CNT_INIT;
      end else if ((state_q == WAIT) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (ent_resp) begin
        rdata_q <= (a_err || a_we) ? 32'd0 : load_ext;
        err_q   <= a_err;
      end else if ((state_q == RESP) && rsp_ready) begin
        rdata_q <= 32'd0;
        err_q   <= 1'b0;
      end
    end
  end

  // Byte-strobed store on the edge entering RESP; storage is never cleared by reset.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder. Instance 0 uses WAIT_STATES=1 and instance 1 uses WAIT_STATES=4.
module tb_dmem_responder;

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  // Clock and reset.
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        req_we     [2];
  logic [2:0]  req_funct3 [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];
  logic        busy       [2];
  logic [1:0]  dbg_state  [2];

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) dut0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_we(req_we[0]),
    .req_funct3(req_funct3[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0]), .dbg_state(dbg_state[0])
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(4)) dut1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_we(req_we[1]),
    .req_funct3(req_funct3[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1]), .dbg_state(dbg_state[1])
  );

  // Scoreboard.
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                         input logic [2:0] f3, input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_lat);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.we = we; v.f3 = f3;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    vecs.push_back(v);
  endtask

  // Driver: issue one request to instance d with rsp_ready high.
  // lat counts edges from the accept edge (inclusive) to the first rsp_valid.
  task automatic do_req(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic we, input logic [2:0] f3,
                        output logic [31:0] rdata, output logic err, output int lat);
    int n;
    @(negedge clk);
    req_addr[d] = addr; req_wdata[d] = wdata; req_we[d] = we; req_funct3[d] = f3;
    req_valid[d] = 1'b1; rsp_ready[d] = 1'b1;
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL accept_timeout: req_ready stayed %b, expected 1", req_ready[d]);
      req_valid[d] = 1'b0;
      rdata = 32'hxxxx_xxxx; err = 1'bx; lat = -1;
      return;
    end
    @(posedge clk);
    #1;
    // Scramble the request inputs once the accept edge has passed.
    req_valid[d] = 1'b0;
    req_addr[d] = $urandom; req_wdata[d] = $urandom;
    req_we[d] = 1'($urandom_range(0, 1)); req_funct3[d] = 3'($urandom_range(0, 7));
    lat = 1;
    while (!rsp_valid[d] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rdata = rsp_rdata[d];
    err = rsp_err[d];
    @(posedge clk);
    #1;
    check("rsp_valid_after_hs", 32'(rsp_valid[d]), 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lt;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
      req_we[d] = 1'b0; req_funct3[d] = 3'd0; rsp_ready[d] = 1'b0;
    end

    // Vector table for instance 0 (WAIT_STATES=1): legal = 2 cycles, error = 1 cycle.
    add_vec(32'h10,   32'hDEADBEEF, 1, F_W,  32'h0,        0, 2);
    add_vec(32'h10,   32'h0,        0, F_W,  32'hDEADBEEF, 0, 2);
    add_vec(32'h11,   32'h12345680, 1, F_B,  32'h0,        0, 2);
    add_vec(32'h11,   32'h0,        0, F_B,  32'hFFFFFF80, 0, 2);
    add_vec(32'h11,   32'h0,        0, F_BU, 32'h00000080, 0, 2);
    add_vec(32'h10,   32'h0,        0, F_W,  32'hDEAD80EF, 0, 2);
    add_vec(32'h20,   32'h11223344, 1, F_W,  32'h0,        0, 2);
    add_vec(32'h22,   32'hABCD8001, 1, F_H,  32'h0,        0, 2);
    add_vec(32'h22,   32'h0,        0, F_H,  32'hFFFF8001, 0, 2);
    add_vec(32'h22,   32'h0,        0, F_HU, 32'h00008001, 0, 2);
    add_vec(32'h20,   32'h0,        0, F_W,  32'h80013344, 0, 2);
    add_vec(32'h20,   32'h0,        0, F_H,  32'h00003344, 0, 2);
    add_vec(32'h23,   32'h0,        0, F_B,  32'hFFFFFF80, 0, 2);
    add_vec(32'h22,   32'h0,        0, F_BU, 32'h00000001, 0, 2);
    add_vec(32'h0,    32'h13579BDF, 1, F_W,  32'h0,        0, 2);
    add_vec(32'hFFC,  32'hCAFEF00D, 1, F_W,  32'h0,        0, 2);
    add_vec(32'hFFC,  32'h0,        0, F_W,  32'hCAFEF00D, 0, 2);
    add_vec(32'h13,   32'h0,        0, F_W,  32'h0,        1, 1);
    add_vec(32'h01,   32'h0,        0, F_H,  32'h0,        1, 1);
    add_vec(32'h10,   32'h0,        0, 3'b011, 32'h0,      1, 1);
    add_vec(32'h1000, 32'h0,        0, F_W,  32'h0,        1, 1);
    add_vec(32'h10,   32'hFFFFFFFF, 1, F_BU, 32'h0,        1, 1);
    add_vec(32'h13,   32'h0,        1, F_W,  32'h0,        1, 1);
    add_vec(32'h1000, 32'hFFFFFFFF, 1, F_W,  32'h0,        1, 1);
    add_vec(32'h10,   32'h0,        0, F_W,  32'hDEAD80EF, 0, 2);
    add_vec(32'h0,    32'h0,        0, F_W,  32'h13579BDF, 0, 2);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("rst_busy",      32'(busy[0]),      32'd0);
    check("rst_rdata",     rsp_rdata[0],      32'd0);
    check("rst_err",       32'(rsp_err[0]),   32'd0);
    check("rst_req_ready", 32'(req_ready[0]), 32'd0);
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    #1;
    check("post_rst_req_ready", 32'(req_ready[0]), 32'd1);
    check("post_rst_state",     32'(dbg_state[0]), 32'd0);

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      exp_q.push_back(vecs[i].exp_rdata);
      do_req(0, vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].f3, rd, er, lt);
      check($sformatf("v%0d_rdata", i), rd, exp_q.pop_front());
      check($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_lat", i), 32'(lt), 32'(vecs[i].exp_lat));
    end

    // Response backpressure: hold rsp_ready low for 5 cycles while a second request waits.
    @(negedge clk);
    req_addr[0] = 32'h20; req_we[0] = 1'b0; req_funct3[0] = F_W; req_valid[0] = 1'b1;
    rsp_ready[0] = 1'b0;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    lt = 1;
    while (!rsp_valid[0] && lt < 40) begin
      @(posedge clk);
      #1;
      lt++;
    end
    check("stall_lat", 32'(lt), 32'd2);
    req_addr[0] = 32'h10; req_we[0] = 1'b1; req_wdata[0] = 32'h0; req_valid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d_valid", k), 32'(rsp_valid[0]), 32'd1);
      check($sformatf("stall%0d_rdata", k), rsp_rdata[0], 32'h80013344);
      check($sformatf("stall%0d_ready", k), 32'(req_ready[0]), 32'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    req_valid[0] = 1'b0; rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    check("release_valid", 32'(rsp_valid[0]), 32'd0);
    check("release_ready", 32'(req_ready[0]), 32'd1);
    check("release_busy",  32'(busy[0]),      32'd0);
    check("release_rdata", rsp_rdata[0],      32'd0);
    @(posedge clk);
    #1;
    check("no_phantom_accept", 32'(busy[0]), 32'd0);
    do_req(0, 32'h10, 32'h0, 1'b0, F_W, rd, er, lt);
    check("post_stall_rdata", rd, 32'hDEAD80EF);
    check("post_stall_lat", 32'(lt), 32'd2);

    // Instance 1: latency with WAIT_STATES=4, then reset while a store is in WAIT.
    do_req(1, 32'h40, 32'h01020304, 1'b1, F_W, rd, er, lt);
    check("ws4_store_lat", 32'(lt), 32'd5);
    check("ws4_store_err", 32'(er), 32'd0);
    @(negedge clk);
    req_addr[1] = 32'h40; req_wdata[1] = 32'h55555555; req_we[1] = 1'b1; req_funct3[1] = F_W;
    req_valid[1] = 1'b1; rsp_ready[1] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    check("ws4_wait_busy", 32'(busy[1]), 32'd1);
    check("ws4_wait_state", 32'(dbg_state[1]), 32'd1);
    rst[1] = 1'b1;
    #1;
    check("midrst_busy",  32'(busy[1]),      32'd0);
    check("midrst_valid", 32'(rsp_valid[1]), 32'd0);
    check("midrst_ready", 32'(req_ready[1]), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b0;
    do_req(1, 32'h40, 32'h0, 1'b0, F_W, rd, er, lt);
    check("midrst_old_data", rd, 32'h01020304);
    check("midrst_lat", 32'(lt), 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
